// File: rtl/dbg_mem_arbiter_if.sv
// rtl/dbg_mem_arbiter_if.sv - uP, memory-channel and debug bus bundle for dbg_mem_arbiter
interface dbg_mem_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int CH_W = $clog2(NUM_CH) + 1;

   // uP side, one slice per channel
   logic [NUM_CH*ADDR_W-1:0] up_addr;
   logic [NUM_CH*DATA_W-1:0] up_wdata;
   logic [NUM_CH-1:0]        up_read;
   logic [NUM_CH-1:0]        up_write;
   logic [NUM_CH-1:0]        up_start;
   logic [NUM_CH-1:0]        up_busy;
   logic [NUM_CH*DATA_W-1:0] up_rdata;
   logic [NUM_CH-1:0]        up_stall;

   // memory-channel side
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [NUM_CH-1:0]        ch_read;
   logic [NUM_CH-1:0]        ch_write;
   logic [NUM_CH-1:0]        ch_start;
   logic [NUM_CH*DATA_W-1:0] ch_rdata;
   logic [NUM_CH-1:0]        ch_done;

   // debug unit side
   logic [DATA_W-1:0]        pc_in;
   logic                     dbg_req;
   logic [1:0]               dbg_op;
   logic [CH_W-1:0]          dbg_ch;
   logic [ADDR_W-1:0]        dbg_addr;
   logic [DATA_W-1:0]        dbg_wdata;
   logic                     dbg_ready;
   logic                     dbg_valid;
   logic [DATA_W-1:0]        dbg_rdata;
   logic                     dbg_err;

   modport slave (
      input  up_addr, up_wdata, up_read, up_write, up_start, up_busy,
      output up_rdata, up_stall,
      output ch_addr, ch_wdata, ch_read, ch_write, ch_start,
      input  ch_rdata, ch_done,
      input  pc_in, dbg_req, dbg_op, dbg_ch, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_valid, dbg_rdata, dbg_err
   );

   modport master (
      output up_addr, up_wdata, up_read, up_write, up_start, up_busy,
      input  up_rdata, up_stall,
      input  ch_addr, ch_wdata, ch_read, ch_write, ch_start,
      output ch_rdata, ch_done,
      output pc_in, dbg_req, dbg_op, dbg_ch, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_valid, dbg_rdata, dbg_err
   );
endinterface

// File: rtl/dbg_mem_arbiter.sv
// rtl/dbg_mem_arbiter.sv - debug/uP memory-channel arbiter; optional DBG_TIMEOUT_EN adds a GRANT/WAIT abort counter
module dbg_mem_arbiter #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   dbg_mem_arbiter_if.slave  bus
);
   localparam int CH_W = $clog2(NUM_CH) + 1;
   localparam logic [CH_W-1:0] NUM_CH_L = CH_W'(NUM_CH);

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_PC  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   // elaboration-time parameter sanity
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("dbg_mem_arbiter: NUM_CH must be 1..8");
   end
   if (TIMEOUT_W < 1) begin : g_bad_timeout_w
      $error("dbg_mem_arbiter: TIMEOUT_W must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q;
   logic [CH_W-1:0]     ch_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;

   logic                accept;
   logic                bad_req;
   logic                busy_sel;
   logic                done_sel;
   logic [DATA_W-1:0]   rdata_sel;
   logic                tmo_hit;
   logic                tmo_abort;
   logic                own_act;
   logic                drive_act;

   assign accept  = bus.dbg_req && (state_q == S_IDLE);
   assign bad_req = (bus.dbg_op == OP_ILL) || (bus.dbg_ch >= NUM_CH_L);

   // pick out busy/done/rdata of the captured target channel
   always_comb begin
      busy_sel  = 1'b0;
      done_sel  = 1'b0;
      rdata_sel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_q == CH_W'(c)) begin
            busy_sel  = bus.up_busy[c];
            done_sel  = bus.ch_done[c];
            rdata_sel = bus.ch_rdata[c*DATA_W +: DATA_W];
         end
      end
   end

`ifdef DBG_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_q;

   assign tmo_hit = ((state_q == S_GRANT) || (state_q == S_WAIT)) && (tmo_q == '1);

   // timeout counter: cleared on entering GRANT, advances while waiting in GRANT/WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else if ((state_d == S_GRANT) && (state_q != S_GRANT)) begin
         tmo_q <= '0;
      end else if ((state_q == S_GRANT) || (state_q == S_WAIT)) begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // a completing transfer wins over a simultaneous timeout
   assign tmo_abort = tmo_hit && !((state_q == S_WAIT) && done_sel);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.dbg_op == OP_PC || bad_req) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_GRANT;
               end
            end
         end
         S_GRANT: begin
            if (tmo_abort) begin
               state_d = S_RESP;
            end else if (!busy_sel) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = done_sel ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (done_sel || tmo_abort) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // captured request fields and response data/error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         ch_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         op_q    <= bus.dbg_op;
         ch_q    <= bus.dbg_ch;
         addr_q  <= bus.dbg_addr;
         wdata_q <= bus.dbg_wdata;
         if (bus.dbg_op == OP_PC) begin
            rdata_q <= bus.pc_in;
            err_q   <= 1'b0;
         end else if (bad_req) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end else begin
            err_q   <= 1'b0;
         end
      end else if (tmo_abort) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
      end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && done_sel && (op_q == OP_RD)) begin
         rdata_q <= rdata_sel;
      end
   end

   // channel ownership: held from GRANT through RESP of a successful memory op
   assign own_act   = (state_q == S_GRANT) || (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                      ((state_q == S_RESP) && !op_q[1] && !err_q);
   assign drive_act = (state_q == S_ISSUE) || (state_q == S_WAIT);

   // FSM outputs: uP pass-through except on the debug-owned channel
   always_comb begin
      bus.ch_addr  = bus.up_addr;
      bus.ch_wdata = bus.up_wdata;
      bus.ch_read  = bus.up_read;
      bus.ch_write = bus.up_write;
      bus.ch_start = bus.up_start;
      bus.up_rdata = bus.ch_rdata;
      bus.up_stall = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (own_act && (ch_q == CH_W'(c))) begin
            bus.up_stall[c]                   = 1'b1;
            bus.up_rdata[c*DATA_W +: DATA_W]  = '0;
            bus.ch_read[c]                    = drive_act && (op_q == OP_RD);
            bus.ch_write[c]                   = drive_act && (op_q == OP_WR);
            bus.ch_start[c]                   = (state_q == S_ISSUE);
            if (drive_act) begin
               bus.ch_addr[c*ADDR_W +: ADDR_W]  = addr_q;
               bus.ch_wdata[c*DATA_W +: DATA_W] = wdata_q;
            end
         end
      end
   end

   assign bus.dbg_ready = (state_q == S_IDLE);
   assign bus.dbg_valid = (state_q == S_RESP);
   assign bus.dbg_rdata = rdata_q;
   assign bus.dbg_err   = err_q;

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// tb/tb_dbg_mem_arbiter.sv - scoreboard bench for dbg_mem_arbiter
module tb_dbg_mem_arbiter;
   localparam int NUM_CH = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   resp_cnt;
   int   dbg_starts [NUM_CH];

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;

   resp_t exp_q [$];

   dbg_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW)) bus ();

   dbg_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // response monitor: pops the scoreboard on every dbg_valid strobe
   always @(negedge clk) begin
      if (rst_n && bus.dbg_valid) begin
         resp_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 64'd1, 64'd0);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", 64'(bus.dbg_rdata), 64'(e.rdata));
            chk("resp_err", 64'(bus.dbg_err), 64'(e.err));
         end
      end
   end

   // count starts issued on debug-owned channels
   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.ch_start[c] && bus.up_stall[c]) dbg_starts[c]++;
         end
      end
   end

   task automatic request(input logic [1:0] op, input logic [1:0] ch,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      bus.dbg_req   = 1'b1;
      bus.dbg_op    = op;
      bus.dbg_ch    = ch;
      bus.dbg_addr  = addr;
      bus.dbg_wdata = wdata;
      step();
      bus.dbg_req   = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; resp_cnt = 0;
      for (int c = 0; c < NUM_CH; c++) dbg_starts[c] = 0;
      rst_n = 1'b0;
      bus.up_addr = '0; bus.up_wdata = '0; bus.up_read = '0; bus.up_write = '0;
      bus.up_start = '0; bus.up_busy = '0; bus.ch_rdata = '0; bus.ch_done = '0;
      bus.pc_in = '0; bus.dbg_req = 1'b0; bus.dbg_op = '0; bus.dbg_ch = '0;
      bus.dbg_addr = '0; bus.dbg_wdata = '0;

      // reset held: random uP traffic passes straight through
      for (int i = 0; i < 3; i++) begin
         bus.up_addr  = {$urandom, $urandom};
         bus.up_wdata = {$urandom, $urandom};
         bus.up_read  = 2'($urandom);
         bus.up_write = 2'($urandom);
         bus.up_start = 2'($urandom);
         step();
         chk("rst_ch_addr", bus.ch_addr, bus.up_addr);
         chk("rst_ch_wdata", bus.ch_wdata, bus.up_wdata);
         chk("rst_ch_ctl", {bus.ch_read, bus.ch_write, bus.ch_start}, {bus.up_read, bus.up_write, bus.up_start});
      end
      chk("rst_ready", 64'(bus.dbg_ready), 64'd1);
      chk("rst_valid", 64'(bus.dbg_valid), 64'd0);
      chk("rst_rdata", 64'(bus.dbg_rdata), 64'd0);
      chk("rst_stall", 64'(bus.up_stall), 64'd0);
      bus.up_addr = '0; bus.up_wdata = '0; bus.up_read = '0; bus.up_write = '0; bus.up_start = '0;
      rst_n = 1'b1;
      step();

      // PC read
      bus.pc_in = 32'h0000_0400;
      exp_q.push_back('{rdata: 32'h0000_0400, err: 1'b0});
      request(2'b10, 2'd0, '0, '0);
      chk("pc_valid_latency", 64'(bus.dbg_valid), 64'd1);
      step();
      chk("pc_back_idle", 64'(bus.dbg_ready), 64'd1);

      // read on ch1 behind 5 busy cycles, done 2 cycles after start
      bus.up_busy[1] = 1'b1;
      bus.up_addr[0*AW +: AW] = 32'h0000_1234;
      bus.up_read[0] = 1'b1;
      exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      request(2'b00, 2'd1, 32'h20, '0);
      for (int i = 0; i < 4; i++) begin
         chk("grant_stall1", 64'(bus.up_stall[1]), 64'd1);
         chk("grant_no_start1", 64'(bus.ch_start[1]), 64'd0);
         chk("ch0_passthru_addr", 64'(bus.ch_addr[0*AW +: AW]), 64'h1234);
         chk("ch0_passthru_rd", {bus.ch_read[0], bus.up_stall[0]}, 64'b10);
         step();
      end
      bus.up_busy[1] = 1'b0;
      step();
      chk("issue_start1", 64'(bus.ch_start[1]), 64'd1);
      chk("issue_addr1", 64'(bus.ch_addr[1*AW +: AW]), 64'h20);
      chk("issue_rw1", {bus.ch_read[1], bus.ch_write[1]}, 64'b10);
      step();
      chk("wait_start1", 64'(bus.ch_start[1]), 64'd0);
      chk("wait_hold1", {bus.ch_read[1], bus.up_stall[1]}, 64'b11);
      step();
      bus.ch_rdata[1*DW +: DW] = 32'hDEAD_BEEF;
      bus.ch_done[1] = 1'b1;
      #1;
      chk("owned_up_rdata1", 64'(bus.up_rdata[1*DW +: DW]), 64'd0);
      step();
      bus.ch_done[1] = 1'b0;
      chk("rd_valid", 64'(bus.dbg_valid), 64'd1);
      step();
      chk("rd_release_stall", 64'(bus.up_stall), 64'd0);
      chk("rd_starts1", 64'(dbg_starts[1]), 64'd1);
      bus.up_read[0] = 1'b0;

      // write on ch0 completing in the ISSUE cycle; rdata holds previous value
      exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      request(2'b01, 2'd0, 32'h10, 32'h5A5A_5A5A);
      step();
      chk("wr_start0", {bus.ch_start[0], bus.ch_write[0], bus.ch_read[0]}, 64'b110);
      chk("wr_wdata0", 64'(bus.ch_wdata[0*DW +: DW]), 64'h5A5A_5A5A);
      chk("wr_addr0", 64'(bus.ch_addr[0*AW +: AW]), 64'h10);
      bus.ch_done[0] = 1'b1;
      step();
      bus.ch_done[0] = 1'b0;
      chk("wr_valid", 64'(bus.dbg_valid), 64'd1);
      step();

      // illegal op, then out-of-range channel
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      request(2'b11, 2'd0, 32'h40, '0);
      chk("ill_valid", 64'(bus.dbg_valid), 64'd1);
      step();
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      request(2'b00, 2'(NUM_CH), 32'h40, '0);
      chk("badch_valid", 64'(bus.dbg_valid), 64'd1);
      chk("badch_no_stall", 64'(bus.up_stall), 64'd0);
      step();
      chk("err_starts0", 64'(dbg_starts[0]), 64'd1);
      chk("err_starts1", 64'(dbg_starts[1]), 64'd1);

      // reset in WAIT aborts without a response
      request(2'b00, 2'd0, 32'h80, '0);
      step();
      step();
      chk("abort_in_wait", {bus.up_stall[0], bus.ch_read[0]}, 64'b11);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 64'(bus.dbg_ready), 64'd1);
      chk("abort_stall", 64'(bus.up_stall), 64'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();

      chk("resp_count", 64'(resp_cnt), 64'd5);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
